// File: rtl/pos_pkg.sv
// Shared types and constants for the position/gray scan-frame stream path.
package pos_pkg;

  localparam int          FRAME_LEN = 811;
  localparam logic [15:0] HDR_TAG   = 16'hA55A;
  localparam logic [7:0]  TRL_TAG   = 8'h5A;

  // Trailer status byte layout
  localparam int ST_ABORTED  = 0;
  localparam int ST_RSVD_LSB = 1;
  localparam int ST_RSVD_MSB = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    BODY    = 2'd2,
    TRAILER = 2'd3
  } state_e;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } stream_word_t;

  typedef struct packed {
    state_e      state;
    logic [15:0] seq;
    logic        aborted;
  } pos_dbg_t;

  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [31:0] w);
    return acc + w[31:16] + w[15:0];
  endfunction

endpackage

// File: rtl/pos_skid_buf.sv
// Two-entry valid/ready skid buffer for {sop, eop, data} stream words.
// Handshake: a word moves when valid && ready on a rising edge; valid and word stay stable until taken.
module pos_skid_buf
  import pos_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  stream_word_t in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output stream_word_t out_word,
  output logic [1:0]   occupancy
);

  stream_word_t head_q, head_d;
  stream_word_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  always_comb begin
    pop      = (count_q != 2'd0) && out_ready;
    in_ready = (count_q != 2'd2) || out_ready;
    push     = in_valid && in_ready;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_word;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_word;
        end else if (push) begin
          tail_d  = in_word;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = in_word;
          else      count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_word  = head_q;
  assign occupancy = count_q;

endmodule

// File: rtl/pos_frame_reader.sv
// Drains one complete scan frame from the distance/gray FIFO and streams it as
// header, body and trailer words, aborting frames whose FIFO dries up mid-drain.
module pos_frame_reader
  import pos_pkg::*;
#(
  parameter int USEDW_W   = 11,
  parameter int STALL_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  input  logic [31:0]        fifo_rddata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic [15:0]        frame_seq,
  output logic [7:0]         abort_cnt,
  output pos_dbg_t           dbg
);

  state_e       state_q, state_d;
  logic [15:0]  rd_issued_q, rd_issued_d;
  logic [15:0]  body_cnt_q, body_cnt_d;
  logic [15:0]  csum_q, csum_d;
  logic [15:0]  seq_q, seq_d;
  logic [15:0]  frame_seq_q, frame_seq_d;
  logic [7:0]   abort_cnt_q, abort_cnt_d;
  logic         aborted_q, aborted_d;
  logic [31:0]  stall_q, stall_d;
  logic         inflight_q;

  logic         rd_req, pop, frame_left, fifo_has;
  logic [2:0]   committed;
  logic [7:0]   status;
  logic         sb_in_valid, sb_in_ready;
  stream_word_t sb_in_word, sb_out_word;
  logic [1:0]   sb_occ;

  always_comb begin
    state_d     = state_q;
    rd_issued_d = rd_issued_q;
    body_cnt_d  = body_cnt_q;
    csum_d      = csum_q;
    seq_d       = seq_q;
    frame_seq_d = frame_seq_q;
    abort_cnt_d = abort_cnt_q;
    aborted_d   = aborted_q;
    stall_d     = stall_q;
    sb_in_valid = 1'b0;
    sb_in_word  = '0;
    rd_req      = 1'b0;
    status      = '0;
    pop         = out_valid && out_ready;
    // Buffer slots already spoken for once this cycle's pop and the pending read land.
    committed   = 3'(sb_occ) - {2'b00, pop} + {2'b00, inflight_q};
    frame_left  = rd_issued_q < 16'(FRAME_LEN);
    fifo_has    = (fifo_usedw != '0);

    case (state_q)
      IDLE: begin
        if (enable && (fifo_usedw >= USEDW_W'(FRAME_LEN))) begin
          state_d     = HEADER;
          rd_issued_d = '0;
          body_cnt_d  = '0;
          csum_d      = '0;
          aborted_d   = 1'b0;
          stall_d     = '0;
        end
      end
      HEADER: begin
        sb_in_valid = 1'b1;
        sb_in_word  = '{sop: 1'b1, eop: 1'b0, data: {HDR_TAG, seq_q}};
        if (sb_in_ready) begin
          state_d = BODY;
          // Issue the first read alongside the header so the body follows it directly.
          rd_req  = frame_left && fifo_has && (committed == 3'd0);
        end
      end
      BODY: begin
        rd_req = frame_left && fifo_has && (committed < 3'd2);
        if (inflight_q) begin
          sb_in_valid = 1'b1;
          sb_in_word  = '{sop: 1'b0, eop: 1'b0, data: fifo_rddata};
          csum_d      = csum_add(csum_q, fifo_rddata);
          body_cnt_d  = body_cnt_q + 16'd1;
          stall_d     = '0;
          if (body_cnt_q == 16'(FRAME_LEN - 1)) state_d = TRAILER;
        end else if (!fifo_has) begin
          if (stall_q == 32'(STALL_CYC - 1)) begin
            aborted_d = 1'b1;
            state_d   = TRAILER;
            stall_d   = '0;
            if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
          end else begin
            stall_d = stall_q + 32'd1;
          end
        end
      end
      TRAILER: begin
        status[ST_ABORTED]              = aborted_q;
        status[ST_RSVD_MSB:ST_RSVD_LSB] = '0;
        sb_in_valid = 1'b1;
        sb_in_word  = '{sop: 1'b0, eop: 1'b1, data: {TRL_TAG, status, csum_q}};
        if (sb_in_ready) begin
          state_d = IDLE;
          if (!aborted_q) begin
            frame_seq_d = seq_q;
            seq_d       = seq_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_req) rd_issued_d = rd_issued_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_issued_q <= '0;
      body_cnt_q  <= '0;
      csum_q      <= '0;
      seq_q       <= '0;
      frame_seq_q <= '0;
      abort_cnt_q <= '0;
      aborted_q   <= 1'b0;
      stall_q     <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_issued_q <= rd_issued_d;
      body_cnt_q  <= body_cnt_d;
      csum_q      <= csum_d;
      seq_q       <= seq_d;
      frame_seq_q <= frame_seq_d;
      abort_cnt_q <= abort_cnt_d;
      aborted_q   <= aborted_d;
      stall_q     <= stall_d;
      inflight_q  <= rd_req;
    end
  end

  pos_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sb_in_valid),
    .in_ready  (sb_in_ready),
    .in_word   (sb_in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (sb_out_word),
    .occupancy (sb_occ)
  );

  assign fifo_rdreq = rd_req;
  assign out_sop    = sb_out_word.sop;
  assign out_eop    = sb_out_word.eop;
  assign out_data   = sb_out_word.data;
  assign frame_seq  = frame_seq_q;
  assign abort_cnt  = abort_cnt_q;
  assign dbg        = '{state: state_q, seq: seq_q, aborted: aborted_q};

endmodule

// File: tb/tb_pos_frame_reader.sv
// Directed bench for pos_frame_reader: FIFO model, output scoreboard and frame scenarios.
module tb_pos_frame_reader;
  import pos_pkg::*;

  localparam int FL    = 811;
  localparam int STALL = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [10:0] fifo_usedw;
  logic        fifo_rdreq;
  logic [31:0] fifo_rddata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] frame_seq;
  logic [7:0]  abort_cnt;
  pos_dbg_t    dbg;

  always #5 clk = ~clk;

  pos_frame_reader #(.USEDW_W(11), .STALL_CYC(STALL)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_usedw  (fifo_usedw),
    .fifo_rdreq  (fifo_rdreq),
    .fifo_rddata (fifo_rddata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .frame_seq   (frame_seq),
    .abort_cnt   (abort_cnt),
    .dbg         (dbg)
  );

  logic [33:0] exp_q[$];
  logic [31:0] fifo_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rd_cnt  = 0;
  int          acc_cnt = 0;
  int          stall_at = -1;
  bit          hold_empty = 1'b0;
  bit          rand_ready = 1'b0;
  bit          prev_stalled = 1'b0;
  logic [33:0] prev_word = '0;
  logic [15:0] exp_seq = 16'd0;
  logic [15:0] exp_frame_seq = 16'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {16'(i), 16'h1000 + 16'(i)};
  endfunction

  task automatic push_fifo(input int first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(word_of(first + i));
  endtask

  task automatic expect_frame(input int first, input int nbody, input bit aborted);
    logic [15:0] cs;
    logic [31:0] w;
    cs = 16'd0;
    exp_q.push_back({1'b1, 1'b0, 16'hA55A, exp_seq});
    for (int i = 0; i < nbody; i++) begin
      w  = word_of(first + i);
      cs = cs + w[31:16] + w[15:0];
      exp_q.push_back({2'b00, w});
    end
    exp_q.push_back({1'b0, 1'b1, 8'h5A, 7'd0, aborted, cs});
    if (!aborted) begin
      exp_frame_seq = exp_seq;
      exp_seq       = exp_seq + 16'd1;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // FIFO with one-cycle read latency; usedw can be pinned to 0 after a chosen read count.
  task automatic fifo_model();
    forever begin
      @(posedge clk);
      if (fifo_rdreq) begin
        rd_cnt++;
        check("fifo_nonempty_on_rdreq", 64'(fifo_q.size() != 0), 64'd1);
        if (fifo_q.size() != 0) fifo_rddata <= fifo_q.pop_front();
      end
      if (stall_at >= 0 && rd_cnt == stall_at) begin
        hold_empty = 1'b1;
        stall_at   = -1;
      end
      fifo_usedw <= hold_empty ? 11'd0 : 11'(fifo_q.size());
    end
  endtask

  task automatic monitor();
    logic [33:0] w;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      w = {out_sop, out_eop, out_data};
      if (prev_stalled) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(w), 64'(prev_word));
      end
      prev_stalled = out_valid && !out_ready;
      prev_word    = w;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) check("extra_word", 64'(w), 64'hDEAD_0000_0000);
        else                   check("out_word", 64'(w), 64'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b1;
    out_ready   = 1'b1;
    fifo_usedw  = '0;
    fifo_rddata = '0;
    fork
      fifo_model();
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_rdreq", 64'(fifo_rdreq), 64'd0);
    check("rst_frame_seq", 64'(frame_seq), 64'd0);
    check("rst_abort_cnt", 64'(abort_cnt), 64'd0);
    check("rst_state", 64'(dbg.state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // 1: single frame, ready held high
    push_fifo(0, FL);
    expect_frame(0, FL, 1'b0);
    wait_drain("t1_drain", 3000);
    check("t1_frame_seq", 64'(frame_seq), 64'(exp_frame_seq));
    check("t1_seq", 64'(dbg.seq), 64'(exp_seq));

    // 2: same frame with random backpressure
    rand_ready = 1'b1;
    push_fifo(0, FL);
    expect_frame(0, FL, 1'b0);
    wait_drain("t2_drain", 8000);
    rand_ready = 1'b0;
    check("t2_frame_seq", 64'(frame_seq), 64'(exp_frame_seq));

    // 3: two frames back to back, exact read count
    @(negedge clk);
    rd_cnt = 0;
    push_fifo(0, 2 * FL);
    expect_frame(0, FL, 1'b0);
    expect_frame(FL, FL, 1'b0);
    wait_drain("t3_drain", 6000);
    check("t3_rd_cnt", 64'(rd_cnt), 64'(2 * FL));
    check("t3_fifo_left", 64'(fifo_q.size()), 64'd0);
    check("t3_frame_seq", 64'(frame_seq), 64'(exp_frame_seq));

    // 4: one word short of a frame, then the last word arrives
    @(negedge clk);
    rd_cnt  = 0;
    acc_cnt = 0;
    push_fifo(0, FL - 1);
    repeat (40) @(negedge clk);
    check("t4_no_rdreq", 64'(rd_cnt), 64'd0);
    check("t4_no_output", 64'(acc_cnt), 64'd0);
    check("t4_idle", 64'(dbg.state), 64'(IDLE));
    push_fifo(FL - 1, 1);
    repeat (2) @(posedge clk);
    #1;
    check("t4_start_latency", 64'(dbg.state != IDLE), 64'd1);
    expect_frame(0, FL, 1'b0);
    wait_drain("t4_drain", 3000);

    // enable low holds IDLE; dropping it mid-frame still completes the frame
    @(negedge clk);
    enable  = 1'b0;
    rd_cnt  = 0;
    acc_cnt = 0;
    push_fifo(0, FL);
    expect_frame(0, FL, 1'b0);
    repeat (30) @(negedge clk);
    check("en_hold_rdreq", 64'(rd_cnt), 64'd0);
    check("en_hold_idle", 64'(dbg.state), 64'(IDLE));
    enable = 1'b1;
    for (int c = 0; c < 2000 && acc_cnt < 100; c++) @(negedge clk);
    enable = 1'b0;
    wait_drain("en_mid_drain", 3000);
    check("en_frame_seq", 64'(frame_seq), 64'(exp_frame_seq));
    enable = 1'b1;

    // 5: FIFO dries up after body word 400 -> aborted frame, then a clean retry
    @(negedge clk);
    rd_cnt   = 0;
    stall_at = 400;
    push_fifo(0, FL);
    expect_frame(0, 400, 1'b1);
    wait_drain("t5_abort_drain", 3000);
    repeat (4) @(negedge clk);
    check("t5_abort_cnt", 64'(abort_cnt), 64'd1);
    check("t5_frame_seq", 64'(frame_seq), 64'(exp_frame_seq));
    check("t5_seq_held", 64'(dbg.seq), 64'(exp_seq));
    check("t5_idle", 64'(dbg.state), 64'(IDLE));
    check("t5_rd_cnt", 64'(rd_cnt), 64'd400);
    fifo_q.delete();
    hold_empty = 1'b0;
    push_fifo(0, FL);
    expect_frame(0, FL, 1'b0);
    wait_drain("t5_retry_drain", 3000);
    check("t5_retry_frame_seq", 64'(frame_seq), 64'(exp_frame_seq));

    // 6: reset in the middle of the body
    @(negedge clk);
    acc_cnt = 0;
    push_fifo(0, FL);
    expect_frame(0, FL, 1'b0);
    for (int c = 0; c < 2000 && acc_cnt < 201; c++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_rdreq", 64'(fifo_rdreq), 64'd0);
    check("t6_state", 64'(dbg.state), 64'(IDLE));
    check("t6_frame_seq", 64'(frame_seq), 64'd0);
    check("t6_abort_cnt", 64'(abort_cnt), 64'd0);
    @(negedge clk);
    exp_q.delete();
    fifo_q.delete();
    exp_seq       = 16'd0;
    exp_frame_seq = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    push_fifo(0, FL);
    expect_frame(0, FL, 1'b0);
    wait_drain("t6_restart_drain", 3000);
    check("t6_seq", 64'(dbg.seq), 64'(exp_seq));

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
